// File: rtl/reg_scoreboard_if.sv
// Decode-group, writeback and status signals exchanged between the decode
// stage and the register scoreboard.
interface reg_scoreboard_if #(
    parameter int NREG = 32
);
    logic            ValidD1, ValidD2, ValidD3, ValidD4;
    logic [4:0]      RsD1, RsD2, RsD3, RsD4;
    logic [4:0]      RtD1, RtD2, RtD3, RtD4;
    logic            RegWriteD1, RegWriteD2, RegWriteD3, RegWriteD4;
    logic [4:0]      WriteRegD1, WriteRegD2, WriteRegD3, WriteRegD4;
    logic            RegWriteW1, RegWriteW2, MemtoRegW3;
    logic [4:0]      WriteRegW1, WriteRegW2, WriteRegW3;
    logic            FlushAll;
    logic            StallD;
    logic [NREG-1:0] PendingVec;
    logic            UnderflowErr;

    // StallD is a hold request back to decode: while it is high the presented
    // group is not allocated and must be presented again unchanged next cycle.
    modport master (
        output ValidD1, ValidD2, ValidD3, ValidD4,
        output RsD1, RsD2, RsD3, RsD4, RtD1, RtD2, RtD3, RtD4,
        output RegWriteD1, RegWriteD2, RegWriteD3, RegWriteD4,
        output WriteRegD1, WriteRegD2, WriteRegD3, WriteRegD4,
        output RegWriteW1, RegWriteW2, MemtoRegW3,
        output WriteRegW1, WriteRegW2, WriteRegW3, FlushAll,
        input  StallD, PendingVec, UnderflowErr
    );

    modport slave (
        input  ValidD1, ValidD2, ValidD3, ValidD4,
        input  RsD1, RsD2, RsD3, RsD4, RtD1, RtD2, RtD3, RtD4,
        input  RegWriteD1, RegWriteD2, RegWriteD3, RegWriteD4,
        input  WriteRegD1, WriteRegD2, WriteRegD3, WriteRegD4,
        input  RegWriteW1, RegWriteW2, MemtoRegW3,
        input  WriteRegW1, WriteRegW2, WriteRegW3, FlushAll,
        output StallD, PendingVec, UnderflowErr
    );
endinterface

// File: rtl/reg_scoreboard.sv
// In-flight write tracker for the 4-wide decode group: per-register counters,
// hazard/capacity stall generation and writeback retirement.
module reg_scoreboard #(
    parameter int CNT_W = 2,
    parameter int NREG  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    reg_scoreboard_if.slave   io_sb
);
    localparam int            SW   = CNT_W + 3;
    localparam logic [SW-1:0] MAXC = SW'((1 << CNT_W) - 1);

    logic [CNT_W-1:0] r_count [NREG];
    logic [NREG-1:0]  r_pend;
    logic             r_uflow;

    logic             w_valid [4];
    logic             w_rw    [4];
    logic [4:0]       w_rs    [4];
    logic [4:0]       w_rt    [4];
    logic [4:0]       w_wd    [4];
    logic             w_wbv   [3];
    logic [4:0]       w_wbr   [3];

    logic [SW-1:0]    w_wbm   [NREG];
    logic [SW-1:0]    w_alloc [NREG];
    logic [SW-1:0]    w_net   [NREG];
    logic [CNT_W-1:0] w_cnt_next [NREG];
    logic [NREG-1:0]  w_pend_next;
    logic             w_uflow;
    logic             w_stall;

    always_comb begin
        w_valid = '{io_sb.ValidD1, io_sb.ValidD2, io_sb.ValidD3, io_sb.ValidD4};
        w_rw    = '{io_sb.RegWriteD1, io_sb.RegWriteD2, io_sb.RegWriteD3, io_sb.RegWriteD4};
        w_rs    = '{io_sb.RsD1, io_sb.RsD2, io_sb.RsD3, io_sb.RsD4};
        w_rt    = '{io_sb.RtD1, io_sb.RtD2, io_sb.RtD3, io_sb.RtD4};
        w_wd    = '{io_sb.WriteRegD1, io_sb.WriteRegD2, io_sb.WriteRegD3, io_sb.WriteRegD4};
        w_wbv   = '{io_sb.RegWriteW1, io_sb.RegWriteW2, io_sb.MemtoRegW3};
        w_wbr   = '{io_sb.WriteRegW1, io_sb.WriteRegW2, io_sb.WriteRegW3};
    end

    // Per-register writeback matches and group allocations; r0 is never counted.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            w_wbm[r]   = '0;
            w_alloc[r] = '0;
        end
        for (int p = 0; p < 3; p++) begin
            if (w_wbv[p] && (w_wbr[p] != '0))
                w_wbm[w_wbr[p]] = w_wbm[w_wbr[p]] + SW'(1);
        end
        for (int k = 0; k < 4; k++) begin
            if (w_valid[k] && w_rw[k] && (w_wd[k] != '0))
                w_alloc[w_wd[k]] = w_alloc[w_wd[k]] + SW'(1);
        end
    end

    // Count after retirement, clamped at zero; a clamp is an underflow.
    always_comb begin
        w_uflow = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            if (SW'(r_count[r]) >= w_wbm[r]) begin
                w_net[r] = SW'(r_count[r]) - w_wbm[r];
            end else begin
                w_net[r] = '0;
                w_uflow  = 1'b1;
            end
        end
    end

    always_comb begin
        logic [4:0] v_src;
        w_stall = 1'b0;
        v_src   = '0;
        for (int k = 0; k < 4; k++) begin
            for (int q = 0; q < 2; q++) begin
                v_src = (q == 0) ? w_rs[k] : w_rt[k];
                if (w_valid[k] && (v_src != '0)) begin
                    // Same-cycle writeback counts as ready: forwarding covers it.
                    if (SW'(r_count[v_src]) > w_wbm[v_src])
                        w_stall = 1'b1;
                    for (int i = 0; i < k; i++) begin
                        if (w_valid[i] && w_rw[i] && (w_wd[i] == v_src))
                            w_stall = 1'b1;
                    end
                end
            end
        end
        for (int r = 1; r < NREG; r++) begin
            if ((w_net[r] + w_alloc[r]) > MAXC)
                w_stall = 1'b1;
        end
    end

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            w_cnt_next[r] = w_stall ? CNT_W'(w_net[r]) : CNT_W'(w_net[r] + w_alloc[r]);
            if (io_sb.FlushAll || (r == 0))
                w_cnt_next[r] = '0;
            w_pend_next[r] = (w_cnt_next[r] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++)
                r_count[r] <= '0;
            r_pend  <= '0;
            r_uflow <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++)
                r_count[r] <= w_cnt_next[r];
            r_pend <= w_pend_next;
            if (w_uflow)
                r_uflow <= 1'b1;
        end
    end

    assign io_sb.StallD       = w_stall;
    assign io_sb.PendingVec   = r_pend;
    assign io_sb.UnderflowErr = r_uflow;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: hazards, capacity, retirement, flush,
// underflow and reset behaviour with hand-computed expectations.
module tb_reg_scoreboard;
    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;

    reg_scoreboard_if #(.NREG(32)) sb ();

    reg_scoreboard #(.CNT_W(2), .NREG(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io_sb (sb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        sb.ValidD1 = 0; sb.ValidD2 = 0; sb.ValidD3 = 0; sb.ValidD4 = 0;
        sb.RsD1 = 0; sb.RsD2 = 0; sb.RsD3 = 0; sb.RsD4 = 0;
        sb.RtD1 = 0; sb.RtD2 = 0; sb.RtD3 = 0; sb.RtD4 = 0;
        sb.RegWriteD1 = 0; sb.RegWriteD2 = 0; sb.RegWriteD3 = 0; sb.RegWriteD4 = 0;
        sb.WriteRegD1 = 0; sb.WriteRegD2 = 0; sb.WriteRegD3 = 0; sb.WriteRegD4 = 0;
        sb.RegWriteW1 = 0; sb.RegWriteW2 = 0; sb.MemtoRegW3 = 0;
        sb.WriteRegW1 = 0; sb.WriteRegW2 = 0; sb.WriteRegW3 = 0;
        sb.FlushAll = 0;
    endtask

    task automatic set_slot(input int k, input logic v, input logic [4:0] rs,
                            input logic [4:0] rt, input logic rw, input logic [4:0] wd);
        case (k)
            1: begin sb.ValidD1 = v; sb.RsD1 = rs; sb.RtD1 = rt; sb.RegWriteD1 = rw; sb.WriteRegD1 = wd; end
            2: begin sb.ValidD2 = v; sb.RsD2 = rs; sb.RtD2 = rt; sb.RegWriteD2 = rw; sb.WriteRegD2 = wd; end
            3: begin sb.ValidD3 = v; sb.RsD3 = rs; sb.RtD3 = rt; sb.RegWriteD3 = rw; sb.WriteRegD3 = wd; end
            default: begin sb.ValidD4 = v; sb.RsD4 = rs; sb.RtD4 = rt; sb.RegWriteD4 = rw; sb.WriteRegD4 = wd; end
        endcase
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pending", sb.PendingVec, 32'h0);
        check("rst_uflow", {31'b0, sb.UnderflowErr}, 32'h0);
        check("rst_stall", {31'b0, sb.StallD}, 32'h0);
        rst_n = 1'b1;
        tick();

        // add r3 <- r1, r2
        set_slot(1, 1, 5'd1, 5'd2, 1, 5'd3);
        #1 check("alloc_r3_stall", {31'b0, sb.StallD}, 32'h0);
        tick();
        check("alloc_r3_pending", sb.PendingVec, 32'h0000_0008);
        check("alloc_r3_count", 32'(dut.r_count[3]), 32'd1);

        // reader of pending r3 stalls, count unchanged
        clear_inputs();
        set_slot(1, 1, 5'd3, 5'd0, 0, 5'd0);
        #1 check("raw_r3_stall", {31'b0, sb.StallD}, 32'h1);
        tick();
        check("raw_r3_count_held", 32'(dut.r_count[3]), 32'd1);

        // same reader with W2 retiring r3 this cycle
        sb.RegWriteW2 = 1; sb.WriteRegW2 = 5'd3;
        #1 check("raw_r3_wb_fwd", {31'b0, sb.StallD}, 32'h0);
        tick();
        check("r3_retired_count", 32'(dut.r_count[3]), 32'd0);
        check("r3_retired_pending", sb.PendingVec, 32'h0);

        // intra-group RAW: slot1 writes r5, slot3 reads rt=r5
        clear_inputs();
        set_slot(1, 1, 5'd1, 5'd2, 1, 5'd5);
        set_slot(3, 1, 5'd1, 5'd5, 0, 5'd0);
        #1 check("intra_raw_stall", {31'b0, sb.StallD}, 32'h1);
        tick();
        check("intra_raw_no_alloc", sb.PendingVec, 32'h0);

        // backward direction: slot1 reads r5, slot3 writes r5
        clear_inputs();
        set_slot(1, 1, 5'd5, 5'd0, 0, 5'd0);
        set_slot(3, 1, 5'd0, 5'd0, 1, 5'd5);
        #1 check("no_backward_dep", {31'b0, sb.StallD}, 32'h0);
        tick();
        check("r5_pending", sb.PendingVec, 32'h0000_0020);

        clear_inputs();
        sb.RegWriteW1 = 1; sb.WriteRegW1 = 5'd5;
        tick();
        check("r5_drained", sb.PendingVec, 32'h0);

        // capacity: four writers of r7 exceed 3
        clear_inputs();
        for (int k = 1; k <= 4; k++) set_slot(k, 1, 5'd0, 5'd0, 1, 5'd7);
        #1 check("cap_four_stall", {31'b0, sb.StallD}, 32'h1);
        tick();
        check("cap_four_no_alloc", sb.PendingVec, 32'h0);

        set_slot(4, 0, 5'd0, 5'd0, 0, 5'd0);
        #1 check("cap_three_ok", {31'b0, sb.StallD}, 32'h0);
        tick();
        check("cap_three_count", 32'(dut.r_count[7]), 32'd3);
        check("cap_three_pending", sb.PendingVec, 32'h0000_0080);

        // full r7: one more writer stalls unless a writeback frees a slot
        clear_inputs();
        set_slot(1, 1, 5'd0, 5'd0, 1, 5'd7);
        #1 check("cap_full_stall", {31'b0, sb.StallD}, 32'h1);
        sb.MemtoRegW3 = 1; sb.WriteRegW3 = 5'd7;
        #1 check("cap_full_wb_ok", {31'b0, sb.StallD}, 32'h0);
        tick();
        check("cap_full_count", 32'(dut.r_count[7]), 32'd3);

        // flush clears everything, blocks the r8 allocation
        clear_inputs();
        set_slot(1, 1, 5'd0, 5'd0, 1, 5'd8);
        sb.FlushAll = 1;
        #1 check("flush_stall", {31'b0, sb.StallD}, 32'h0);
        tick();
        check("flush_pending", sb.PendingVec, 32'h0);
        check("flush_count7", 32'(dut.r_count[7]), 32'd0);
        check("flush_uflow", {31'b0, sb.UnderflowErr}, 32'h0);

        // double writeback on r6 in one cycle
        clear_inputs();
        set_slot(1, 1, 5'd0, 5'd0, 1, 5'd6);
        set_slot(2, 1, 5'd0, 5'd0, 1, 5'd6);
        #1 check("waw_ok", {31'b0, sb.StallD}, 32'h0);
        tick();
        check("waw_count", 32'(dut.r_count[6]), 32'd2);
        clear_inputs();
        set_slot(1, 1, 5'd6, 5'd6, 0, 5'd0);
        sb.RegWriteW1 = 1; sb.WriteRegW1 = 5'd6;
        #1 check("one_wb_of_two_stall", {31'b0, sb.StallD}, 32'h1);
        sb.RegWriteW2 = 1; sb.WriteRegW2 = 5'd6;
        #1 check("two_wb_ok", {31'b0, sb.StallD}, 32'h0);
        tick();
        check("two_wb_count", 32'(dut.r_count[6]), 32'd0);
        check("two_wb_uflow", {31'b0, sb.UnderflowErr}, 32'h0);

        // underflow on r9
        clear_inputs();
        sb.MemtoRegW3 = 1; sb.WriteRegW3 = 5'd9;
        tick();
        check("uflow_set", {31'b0, sb.UnderflowErr}, 32'h1);
        check("uflow_count9", 32'(dut.r_count[9]), 32'd0);
        check("uflow_pending", sb.PendingVec, 32'h0);
        clear_inputs();
        sb.FlushAll = 1;
        tick();
        check("uflow_sticky_flush", {31'b0, sb.UnderflowErr}, 32'h1);
        clear_inputs();
        rst_n = 1'b0;
        #1 check("uflow_reset", {31'b0, sb.UnderflowErr}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // r0 is never tracked
        set_slot(1, 1, 5'd1, 5'd2, 1, 5'd0);
        set_slot(2, 1, 5'd0, 5'd0, 0, 5'd0);
        sb.RegWriteW1 = 1; sb.WriteRegW1 = 5'd0;
        #1 check("r0_stall", {31'b0, sb.StallD}, 32'h0);
        tick();
        check("r0_pending", sb.PendingVec, 32'h0);
        check("r0_uflow", {31'b0, sb.UnderflowErr}, 32'h0);
        check("r0_count", 32'(dut.r_count[0]), 32'd0);

        // async reset in the middle of a stall
        clear_inputs();
        set_slot(1, 1, 5'd0, 5'd0, 1, 5'd4);
        tick();
        check("r4_pending", sb.PendingVec, 32'h0000_0010);
        clear_inputs();
        set_slot(1, 1, 5'd4, 5'd0, 0, 5'd0);
        #1 check("r4_stall", {31'b0, sb.StallD}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("midstall_rst_stall", {31'b0, sb.StallD}, 32'h0);
        check("midstall_rst_pending", sb.PendingVec, 32'h0);
        check("midstall_rst_count", 32'(dut.r_count[4]), 32'd0);
        tick();
        rst_n = 1'b1;
        clear_inputs();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
